// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings and
// the default WAIT-state timeout.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

  localparam int unsigned DEF_MEM_TIMEOUT = 16;

endpackage

// File: rtl/fetch_timer.sv
// WAIT-state watchdog: clears on entry to WAIT, counts while enabled and
// flags expiry during the LIMIT-th enabled cycle.
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  // Saturates at LIMIT so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != CW'(LIMIT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = enable && (r_count >= CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit between the core and instruction
// memory. Define FETCH_MISALIGN_CHECK_EN to trap misaligned pc instead of aligning it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            fetch_en,
  input  logic            redirect,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            pc_stall,
  output logic            fetch_err
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_addr_q;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_discard_q;
  logic            w_discard_next;
  logic            w_latch;
  logic            w_capture;
  logic            w_expired;
  logic [XLEN-1:0] w_fetch_addr;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_fetch_addr = pc;
`else
  assign w_fetch_addr = pc & {{(XLEN-2){1'b1}}, 2'b00};
`endif

  fetch_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((r_state == REQ) && imem_gnt),
    .enable  (r_state == WAIT),
    .expired (w_expired)
  );

  always_comb begin
    w_state_next   = r_state;
    w_latch        = 1'b0;
    w_capture      = 1'b0;
    w_discard_next = r_discard_q;
    if (imem_rvalid && r_discard_q) begin
      w_discard_next = 1'b0;
    end
    case (r_state)
      IDLE: begin
        if (fetch_en && !r_discard_q) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            w_state_next = ERR;
          end else begin
            w_latch      = 1'b1;
            w_state_next = REQ;
          end
`else
          w_latch      = 1'b1;
          w_state_next = REQ;
`endif
        end
      end
      REQ: begin
        if (imem_gnt) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_capture    = 1'b1;
          w_state_next = VALID;
        end else if (w_expired) begin
          w_state_next = ERR;
        end
      end
      VALID: begin
        if (instr_ready) begin
          w_state_next = IDLE;
        end
      end
      ERR: begin
        w_state_next = ERR;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // Redirect wins over everything; a response already accepted by memory
    // but not yet returned must be swallowed when it arrives.
    if (redirect) begin
      w_state_next = IDLE;
      w_latch      = 1'b0;
      w_capture    = 1'b0;
      if (((r_state == WAIT) && !imem_rvalid) || ((r_state == REQ) && imem_gnt)) begin
        w_discard_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr_q    <= '0;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_discard_q <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_discard_q <= w_discard_next;
      if (w_latch) begin
        r_addr_q <= w_fetch_addr;
      end
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_addr_q;
      end
    end
  end

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_addr_q;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = (r_state == VALID);
  assign fetch_err   = (r_state == ERR);
  assign pc_stall    = !reset && fetch_en && !((r_state == VALID) && instr_ready);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: cycle vector table, directed multi-cycle sequences,
// and randomized traffic against a transaction-level memory/core model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_en;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_stall;
  logic        fetch_err;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_stall    (pc_stall),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst, fe, rd, g, rv, rdy;
    logic [31:0] pcv, rdat;
    logic        e_req, e_valid, e_stall, e_err;
    logic [31:0] e_addr, e_instr, e_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic fe, logic [31:0] pcv, logic rd, logic g,
                              logic rv, logic [31:0] rdat, logic rdy, logic e_req,
                              logic [31:0] e_addr, logic e_valid, logic [31:0] e_instr,
                              logic [31:0] e_ipc, logic e_stall, logic e_err);
    vec_t v;
    v.rst = rst; v.fe = fe; v.pcv = pcv; v.rd = rd; v.g = g; v.rv = rv; v.rdat = rdat;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_stall = e_stall; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic fe, input logic [31:0] p, input logic rd, input logic g,
                        input logic rv, input logic [31:0] rdat, input logic rdy);
    fetch_en = fe; pc = p; redirect = rd; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rdat; instr_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] rnd_pc();
    logic [31:0] r;
    r = $urandom;
    return {r[31:2], 2'b00};
  endfunction

  // Slow memory: grant after 3 cycles, data 5 cycles after grant.
  task automatic seq_slow();
    int nvalid;
    do_reset();
    set_in(1, 'h50, 0, 0, 0, 0, 0);
    chkb("slow_stall_idle", pc_stall, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 'h50, 0, 0, 0, 0, 0);
      chkb("slow_req_held", imem_req, 1);
      chk("slow_addr_stable", imem_addr, 'h50);
      chkb("slow_stall_req", pc_stall, 1);
      tick();
    end
    set_in(1, 'h50, 0, 1, 0, 0, 0);
    chkb("slow_req_gnt", imem_req, 1);
    chk("slow_addr_gnt", imem_addr, 'h50);
    tick();
    for (int i = 1; i <= 5; i++) begin
      set_in(1, 'h50, 0, 0, (i == 5), 'hA5A50013, 0);
      chkb("slow_no_req_wait", imem_req, 0);
      chkb("slow_stall_wait", pc_stall, 1);
      chkb("slow_no_valid_wait", instr_valid, 0);
      tick();
    end
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      set_in((i == 0), 'h50, 0, 0, 0, 0, 1);
      if (instr_valid) begin
        nvalid++;
        chk("slow_instr", instr, 'hA5A50013);
        chk("slow_instr_pc", instr_pc, 'h50);
        chkb("slow_stall_consume", pc_stall, 0);
      end
      tick();
    end
    chk("slow_valid_count", 32'(nvalid), 1);
  endtask

  // Timeout: no rvalid ever; error after MEM_TIMEOUT WAIT cycles, held until redirect.
  task automatic seq_timeout();
    int nwait;
    do_reset();
    set_in(1, 'h20, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 'h20, 0, 1, 0, 0, 0);
    tick();
    nwait = 0;
    while (!fetch_err && nwait < 40) begin
      set_in(1, 'h20, 0, 0, 0, 0, 0);
      tick();
      nwait++;
    end
    chk("timeout_wait_cycles", 32'(nwait), 16);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 'h20, 0, 0, 0, 0, 1);
      chkb("timeout_err_held", fetch_err, 1);
      chkb("timeout_no_req", imem_req, 0);
      chkb("timeout_stall", pc_stall, 1);
      tick();
    end
    set_in(0, 0, 1, 0, 0, 0, 0);
    chkb("timeout_err_before_redirect", fetch_err, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chkb("timeout_err_cleared", fetch_err, 0);
    chkb("timeout_req_after", imem_req, 0);
    tick();
  endtask

  task automatic seq_misalign();
    do_reset();
    set_in(1, 'h12, 0, 0, 0, 0, 0);
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 2; i++) begin
      set_in(1, 'h12, 0, 0, 0, 0, 0);
      chkb("misalign_err", fetch_err, 1);
      chkb("misalign_no_req", imem_req, 0);
      tick();
    end
    set_in(0, 0, 1, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chkb("misalign_err_cleared", fetch_err, 0);
    tick();
`else
    set_in(1, 'h12, 0, 1, 0, 0, 0);
    chkb("align_req", imem_req, 1);
    chk("align_addr", imem_addr, 'h10);
    chkb("align_no_err", fetch_err, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 'h00A00113, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1);
    chkb("align_valid", instr_valid, 1);
    chk("align_instr_pc", instr_pc, 'h10);
    chkb("align_no_err2", fetch_err, 0);
    tick();
`endif
  endtask

  // Random core/memory traffic; the model knows only which pc the core asked
  // for and what memory holds at each address.
  task automatic run_random(input int ncyc);
    logic [31:0] want, paddr, prev_addr, rdat;
    logic        fe, rd, g, rv, rdy, pend, prev_hold, prev_rd;
    int          pcnt, age, delivered;
    do_reset();
    want = rnd_pc(); pend = 0; pcnt = 0; paddr = 0; prev_addr = 0;
    prev_hold = 0; prev_rd = 0; age = 0; delivered = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (prev_rd) chkb("rnd_flush_valid", instr_valid, 0);
      if (prev_hold) begin
        chkb("rnd_req_hold", imem_req, 1);
        chk("rnd_addr_hold", imem_addr, prev_addr);
      end
      chkb("rnd_one_outstanding", imem_req && pend, 0);
      chkb("rnd_no_err", fetch_err, 0);
      rd   = ($urandom_range(0, 19) == 0);
      fe   = !rd;
      rdy  = ($urandom_range(0, 2) != 0);
      rv   = pend && (pcnt == 0);
      rdat = rv ? memf(paddr) : $urandom;
      g    = imem_req && !pend && ($urandom_range(0, 2) == 0);
      set_in(fe, want, rd, g, rv, rdat, rdy);
      if (!fe) chkb("rnd_stall_idle", pc_stall, 0);
      else if (!rdy) chkb("rnd_stall_busy", pc_stall, 1);
      if (instr_valid && rdy && !rd) begin
        chk("rnd_instr_pc", instr_pc, want);
        chk("rnd_instr", instr, memf(want));
        delivered++;
        age = 0;
        want = rnd_pc();
      end else if (rd) begin
        age = 0;
        want = rnd_pc();
      end else begin
        age++;
        if (age > 60) begin
          chk("rnd_liveness_cycles", 32'(age), 60);
          age = 0;
        end
      end
      prev_hold = imem_req && !g && !rd;
      prev_addr = imem_addr;
      prev_rd   = rd;
      if (g) begin
        pend = 1; paddr = imem_addr; pcnt = $urandom_range(0, 3);
      end else if (rv) begin
        pend = 0;
      end else if (pend) begin
        pcnt--;
      end
      tick();
    end
    chkb("rnd_enough_deliveries", delivered > 50, 1);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Basic fetch, redirect in WAIT with stale data, reset in WAIT.
    tbl.push_back(mk(1, 0, 0,    0, 0, 0, 0,           0, 0, 0,    0, 0,           0,    0, 0));
    tbl.push_back(mk(0, 1, 'h10, 0, 0, 0, 0,           0, 0, 0,    0, 0,           0,    1, 0));
    tbl.push_back(mk(0, 1, 'h10, 0, 1, 0, 0,           0, 1, 'h10, 0, 0,           0,    1, 0));
    tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h00500093,  0, 0, 'h10, 0, 0,           0,    1, 0));
    tbl.push_back(mk(0, 1, 'h10, 0, 0, 0, 0,           1, 0, 'h10, 1, 'h00500093,  'h10, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0, 0,           0, 0, 'h10, 0, 'h00500093,  'h10, 0, 0));
    tbl.push_back(mk(0, 1, 'h30, 0, 0, 0, 0,           0, 0, 'h10, 0, 'h00500093,  'h10, 1, 0));
    tbl.push_back(mk(0, 1, 'h30, 0, 1, 0, 0,           0, 1, 'h30, 0, 'h00500093,  'h10, 1, 0));
    tbl.push_back(mk(0, 0, 0,    1, 0, 0, 0,           0, 0, 'h30, 0, 'h00500093,  'h10, 0, 0));
    tbl.push_back(mk(0, 1, 'h40, 0, 0, 0, 0,           0, 0, 'h30, 0, 'h00500093,  'h10, 1, 0));
    tbl.push_back(mk(0, 1, 'h40, 0, 0, 0, 0,           0, 0, 'h30, 0, 'h00500093,  'h10, 1, 0));
    tbl.push_back(mk(0, 1, 'h40, 0, 0, 1, 'hDEADBEEF,  0, 0, 'h30, 0, 'h00500093,  'h10, 1, 0));
    tbl.push_back(mk(0, 1, 'h40, 0, 0, 0, 0,           0, 0, 'h30, 0, 'h00500093,  'h10, 1, 0));
    tbl.push_back(mk(0, 1, 'h40, 0, 1, 0, 0,           0, 1, 'h40, 0, 'h00500093,  'h10, 1, 0));
    tbl.push_back(mk(0, 1, 'h40, 0, 0, 1, 'h11111111,  0, 0, 'h40, 0, 'h00500093,  'h10, 1, 0));
    tbl.push_back(mk(0, 1, 'h40, 0, 0, 0, 0,           1, 0, 'h40, 1, 'h11111111,  'h40, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0, 0,           0, 0, 'h40, 0, 'h11111111,  'h40, 0, 0));
    tbl.push_back(mk(0, 1, 'h60, 0, 0, 0, 0,           0, 0, 'h40, 0, 'h11111111,  'h40, 1, 0));
    tbl.push_back(mk(0, 1, 'h60, 0, 1, 0, 0,           0, 1, 'h60, 0, 'h11111111,  'h40, 1, 0));
    tbl.push_back(mk(1, 0, 0,    0, 0, 0, 0,           0, 0, 'h60, 0, 'h11111111,  'h40, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 1, 'hCAFEF00D,  0, 0, 0,    0, 0,           0,    0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0, 0,           0, 0, 0,    0, 0,           0,    0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      set_in(tbl[i].fe, tbl[i].pcv, tbl[i].rd, tbl[i].g, tbl[i].rv, tbl[i].rdat, tbl[i].rdy);
      chkb($sformatf("vec%0d_imem_req", i), imem_req, tbl[i].e_req);
      chk($sformatf("vec%0d_imem_addr", i), imem_addr, tbl[i].e_addr);
      chkb($sformatf("vec%0d_instr_valid", i), instr_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
      chkb($sformatf("vec%0d_pc_stall", i), pc_stall, tbl[i].e_stall);
      chkb($sformatf("vec%0d_fetch_err", i), fetch_err, tbl[i].e_err);
      tick();
    end
    reset = 1'b0;

    seq_slow();
    seq_timeout();
    seq_misalign();
    run_random(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set address and instruction width.
REQ-002 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles before an error.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port pc, input, XLEN: current PC from the PC register.
REQ-006 Port fetch_en, input, 1: core requests the instruction at pc.
REQ-007 Port redirect, input, 1: taken branch/jump; flushes any in-flight fetch.
REQ-008 Ports to instruction memory, all 1 bit unless noted:
- imem_req, output: request.
- imem_addr, output, XLEN: request address.
- imem_gnt, input: request accepted.
- imem_rvalid, input: read data valid.
- imem_rdata, input, XLEN: read data.
REQ-009 Ports to the core:
- instr, output, XLEN: fetched instruction.
- instr_pc, output, XLEN: address it came from.
- instr_valid, output, 1: instr and instr_pc are valid.
- instr_ready, input, 1: core consumes instr.
- pc_stall, output, 1: core holds pc_next = pc.
- fetch_err, output, 1: fetch fault.

Function
REQ-010 FSM states SHALL be IDLE, REQ, WAIT, VALID, ERR.
REQ-011 IDLE: if fetch_en and no response pending discard, SHALL latch pc into addr_q and go to REQ.
REQ-012 REQ: imem_req=1 and imem_addr=addr_q; SHALL stay in REQ until imem_gnt, then go to WAIT.
REQ-013 Once asserted, imem_req and imem_addr SHALL stay stable until imem_gnt.
REQ-014 WAIT: on imem_rvalid, SHALL capture imem_rdata into instr and addr_q into instr_pc, then go to VALID.
REQ-015 WAIT timeout: a counter SHALL clear on entry to WAIT and increment each cycle; on reaching MEM_TIMEOUT without rvalid the FSM SHALL go to ERR.
REQ-016 VALID: instr_valid=1 and instr/instr_pc held stable until instr_ready, then go to IDLE.
REQ-017 ERR: fetch_err=1, held until redirect or reset; no requests SHALL be issued.
REQ-018 pc_stall SHALL be 1 whenever fetch_en=1 and not (state==VALID and instr_ready).
REQ-019 Minimum latency: fetch_en in cycle N, imem_req in N+1, gnt in N+1, rvalid in N+2, instr_valid in N+3.
REQ-020 At most one request SHALL be outstanding at any time.
REQ-021 Redirect handling, any state: redirect SHALL force IDLE next cycle and deassert instr_valid.
REQ-022 Redirect while in WAIT, or in REQ in the same cycle as imem_gnt, SHALL set discard_q.
- The next imem_rvalid SHALL clear discard_q and be dropped.
- IDLE SHALL not issue a new request while discard_q=1.
REQ-023 Redirect in the same cycle as rvalid in WAIT: data SHALL be dropped and discard_q left clear.
REQ-024 Redirect in REQ without imem_gnt: request SHALL be withdrawn and discard_q left clear.
REQ-025 Redirect has priority over instr_ready, imem_rvalid and the timeout.

Reset
REQ-026 When reset=1 at a clk edge, the block SHALL set:
- state=IDLE.
- imem_req=0, imem_addr=0.
- instr=0, instr_pc=0, instr_valid=0.
- fetch_err=0, pc_stall=0.
- discard_q=0, timeout counter=0.
REQ-027 Reset mid-transaction SHALL abandon it; a late imem_rvalid after reset SHALL be ignored.

Configuration
REQ-028 With FETCH_MISALIGN_CHECK_EN defined, fetch_en in IDLE with pc[1:0]!=0 SHALL go to ERR with no memory request.
REQ-029 Without FETCH_MISALIGN_CHECK_EN, imem_addr[1:0] SHALL be forced to 00 and no misalignment error SHALL be raised.

Structure
REQ-030 Package fetch_pkg SHALL hold the FSM state encodings and the default MEM_TIMEOUT constant.
REQ-031 The timeout counter SHALL be a sub-module fetch_timer with clear, enable, and expired ports.

Verification
REQ-032 Basic fetch: pc=0x10, fetch_en=1, gnt immediate, rvalid one cycle later, rdata=0x00500093 -> instr_valid in cycle N+3 with instr=0x00500093 and instr_pc=0x10.
REQ-033 Slow memory: gnt delayed 3 cycles, rvalid 5 cycles after gnt -> imem_addr stable during REQ, pc_stall=1 throughout, and a single instr_valid.
REQ-034 Redirect in WAIT: redirect, then fetch_en with pc=0x40 -> old rvalid (0xDEADBEEF) dropped, then new fetch delivers instr_pc=0x40.
REQ-035 Timeout: MEM_TIMEOUT=16 and no rvalid -> fetch_err=1 after 16 WAIT cycles, held until redirect.
REQ-036 Misalignment: pc=0x12 with the macro defined -> fetch_err=1 and imem_req stays 0; without the macro -> imem_addr=0x10.
REQ-037 Reset during WAIT: reset for 1 cycle, then rvalid -> no instr_valid and all outputs at reset values.
